// File: rtl/camera_crop_pkg.sv
// camera_crop_pkg: shared FSM state, counter width and window compare
// for the raw-Bayer crop front-end.
package camera_crop_pkg;

  typedef enum logic [1:0] {
    SKIP  = 2'd0,
    WAIT  = 2'd1,
    FRAME = 2'd2
  } crop_state_e;

  localparam int CNT_W_DEF = 12;

  // 32-bit compare leaves headroom above CNT_W for lo+len.
  function automatic logic in_span(
    input logic [31:0] v,
    input logic [31:0] lo,
    input logic [31:0] len
  );
    return (v >= lo) && (v < lo + len);
  endfunction

endpackage

// File: rtl/camera_sync_counter.sv
// camera_sync_counter: x/y position counters, edge detect, line/frame
// length capture. In: fval, lval, cap_en. Out: x, y, edges, lengths.
module camera_sync_counter #(
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fval,
  input  logic             lval,
  input  logic             cap_en,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             fval_rise,
  output logic             fval_fall,
  output logic             lv_fall,
  output logic [CNT_W-1:0] line_len,
  output logic [CNT_W-1:0] frame_lines
);

  localparam logic [CNT_W-1:0] SAT = '1;
  localparam logic [CNT_W-1:0] ONE = 1;

  logic             lv;
  logic             lv_p_q, lv_p_d;
  logic             fval_p_q, fval_p_d;
  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] lines_q, lines_d;

  // lval outside fval is ignored entirely.
  assign lv        = lval & fval;
  assign lv_fall   = lv_p_q & ~lv;
  assign fval_rise = fval & ~fval_p_q;
  assign fval_fall = ~fval & fval_p_q;

  always_comb begin
    lv_p_d   = lv;
    fval_p_d = fval;
    x_d      = '0;
    if (lv) begin
      x_d = (x_q == SAT) ? x_q : x_q + ONE;
    end
    y_d = y_q;
    if (!fval) begin
      y_d = '0;
    end else if (lv_fall) begin
      y_d = (y_q == SAT) ? y_q : y_q + ONE;
    end
    len_d   = lv_fall ? x_q : len_q;
    lines_d = (fval_fall && cap_en) ? y_q : lines_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lv_p_q   <= 1'b0;
      fval_p_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      len_q    <= '0;
      lines_q  <= '0;
    end else begin
      lv_p_q   <= lv_p_d;
      fval_p_q <= fval_p_d;
      x_q      <= x_d;
      y_q      <= y_d;
      len_q    <= len_d;
      lines_q  <= lines_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign line_len    = len_q;
  assign frame_lines = lines_q;

endmodule

// File: rtl/camera_raw_window_crop.sv
// camera_raw_window_crop: registers sensor pins, drops partial frames,
// crops a pixel/line window, regenerates fval/lval, reports status.
module camera_raw_window_crop
  import camera_crop_pkg::*;
#(
  parameter int DATA_W  = 12,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int CROP_X0 = 16,
  parameter int CROP_Y0 = 8,
  parameter int CROP_W  = 800,
  parameter int CROP_H  = 480
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              crop_en,
  input  logic [DATA_W-1:0] in_d,
  input  logic              in_fval,
  input  logic              in_lval,
  output logic [DATA_W-1:0] out_d,
  output logic              out_fval,
  output logic              out_lval,
  output logic [15:0]       frame_count,
  output logic [CNT_W-1:0]  last_line_len,
  output logic [CNT_W-1:0]  last_frame_lines,
  output logic              short_frame,
  output logic              short_line
);

  logic [DATA_W-1:0] d_q;
  logic              fval_q;
  logic              lval_q;
  logic              primed_q;

  crop_state_e state_q, state_d;
  logic        mode_q, mode_d;

  logic [DATA_W-1:0] out_d_q, out_d_d;
  logic              out_fval_q, out_fval_d;
  logic              out_lval_q, out_lval_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              sf_q, sf_d;
  logic              sl_q, sl_d;

  logic [CNT_W-1:0] x, y;
  logic             fval_rise, fval_fall, lv_fall;
  logic             in_frame, act, md;
  logic             x_win, y_win, hit;

  assign in_frame = (state_q == FRAME);

  camera_sync_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk        (clk),
    .rst_n      (reset_n),
    .fval       (fval_q),
    .lval       (lval_q),
    .cap_en     (in_frame),
    .x          (x),
    .y          (y),
    .fval_rise  (fval_rise),
    .fval_fall  (fval_fall),
    .lv_fall    (lv_fall),
    .line_len   (last_line_len),
    .frame_lines(last_frame_lines)
  );

  // The rise cycle already counts as in-frame so latency stays fixed.
  assign act = in_frame || (state_q == WAIT && fval_rise);
  assign md  = in_frame ? mode_q : crop_en;

  assign x_win = in_span(32'(x), 32'(CROP_X0), 32'(CROP_W));
  assign y_win = in_span(32'(y), 32'(CROP_Y0), 32'(CROP_H));
  assign hit   = act && lval_q && fval_q && (!md || (x_win && y_win));

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    unique case (state_q)
      // primed_q keeps the reset value of fval_q from faking a gap.
      SKIP:    if (primed_q && !fval_q) state_d = WAIT;
      WAIT: begin
        if (fval_rise) begin
          state_d = FRAME;
          mode_d  = crop_en;
        end
      end
      FRAME:   if (fval_fall) state_d = WAIT;
      default: state_d = SKIP;
    endcase

    out_lval_d = hit;
    out_d_d    = hit ? d_q : '0;
    out_fval_d = act && fval_q && (!md || y_win);

    cnt_d = cnt_q;
    if (out_fval_q && !out_fval_d) cnt_d = cnt_q + 16'd1;

    sf_d = fval_fall && in_frame && mode_q &&
           in_span(32'(y), 32'd0, 32'(CROP_Y0 + CROP_H));
    sl_d = lv_fall && in_frame && mode_q && y_win &&
           in_span(32'(x), 32'd0, 32'(CROP_X0 + CROP_W));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_q        <= '0;
      fval_q     <= 1'b0;
      lval_q     <= 1'b0;
      primed_q   <= 1'b0;
      state_q    <= SKIP;
      mode_q     <= 1'b0;
      out_d_q    <= '0;
      out_fval_q <= 1'b0;
      out_lval_q <= 1'b0;
      cnt_q      <= '0;
      sf_q       <= 1'b0;
      sl_q       <= 1'b0;
    end else begin
      d_q        <= in_d;
      fval_q     <= in_fval;
      lval_q     <= in_lval;
      primed_q   <= 1'b1;
      state_q    <= state_d;
      mode_q     <= mode_d;
      out_d_q    <= out_d_d;
      out_fval_q <= out_fval_d;
      out_lval_q <= out_lval_d;
      cnt_q      <= cnt_d;
      sf_q       <= sf_d;
      sl_q       <= sl_d;
    end
  end

  assign out_d       = out_d_q;
  assign out_fval    = out_fval_q;
  assign out_lval    = out_lval_q;
  assign frame_count = cnt_q;
  assign short_frame = sf_q;
  assign short_line  = sl_q;

endmodule

// File: tb/tb_camera_raw_window_crop.sv
// tb_camera_raw_window_crop: directed frames on a scaled-down window,
// hand-computed burst counts, lengths, latency and status checks.
module tb_camera_raw_window_crop;

  localparam int X0 = 4;
  localparam int Y0 = 3;
  localparam int W  = 10;
  localparam int H  = 5;
  localparam int FW = 20;
  localparam int FH = 12;
  localparam int HB = 4;
  localparam int VB = 6;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        crop_en;
  logic [11:0] in_d;
  logic        in_fval;
  logic        in_lval;
  logic [11:0] out_d;
  logic        out_fval;
  logic        out_lval;
  logic [15:0] frame_count;
  logic [11:0] last_line_len;
  logic [11:0] last_frame_lines;
  logic        short_frame;
  logic        short_line;

  camera_raw_window_crop #(
    .DATA_W (12),
    .CNT_W  (12),
    .CROP_X0(X0),
    .CROP_Y0(Y0),
    .CROP_W (W),
    .CROP_H (H)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .crop_en         (crop_en),
    .in_d            (in_d),
    .in_fval         (in_fval),
    .in_lval         (in_lval),
    .out_d           (out_d),
    .out_fval        (out_fval),
    .out_lval        (out_lval),
    .frame_count     (frame_count),
    .last_line_len   (last_line_len),
    .last_frame_lines(last_frame_lines),
    .short_frame     (short_frame),
    .short_line      (short_line)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] pix(input int x, input int y);
    return {y[5:0], x[5:0]};
  endfunction

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int ex0, ey0;
  int pix_cyc = 0;
  int fall_cyc = 0;

  int bursts = 0, derr = 0, act = 0, sf_n = 0, sl_n = 0;
  int ofall_cyc = 0, ox = 0, oy = 0, blen_cur = 0;
  int blen [0:255];
  logic [11:0] bd0 [0:255];
  int bcyc [0:255];
  logic pl = 1'b0;
  logic pf = 1'b0;

  always @(negedge clk) begin
    int oyc;
    pl <= out_lval;
    pf <= out_fval;
    oyc = (out_fval && !pf) ? 0 : oy;
    if (out_lval || out_fval || out_d != 12'd0) act <= act + 1;
    if (!out_fval && pf) ofall_cyc <= cyc;
    if (short_frame) sf_n <= sf_n + 1;
    if (short_line) sl_n <= sl_n + 1;
    if (!out_lval && out_d != 12'd0) derr <= derr + 1;
    if (out_lval) begin
      if (out_d != pix(ex0 + (pl ? ox : 0), ey0 + oyc)) derr <= derr + 1;
      if (!pl) begin
        if (bursts < 256) begin
          bd0[bursts]  <= out_d;
          bcyc[bursts] <= cyc;
        end
        ox       <= 1;
        blen_cur <= 1;
      end else begin
        ox       <= ox + 1;
        blen_cur <= blen_cur + 1;
      end
    end
    if (!out_lval && pl) begin
      if (bursts < 256) blen[bursts] <= blen_cur;
      bursts <= bursts + 1;
      oyc = oyc + 1;
    end
    oy <= oyc;
  end

  int b0, d0, a0, s0, l0;

  task automatic snap();
    b0 = bursts;
    d0 = derr;
    a0 = act;
    s0 = sf_n;
    l0 = sl_n;
  endtask

  task automatic send_frame(input int lines, input int sl_y,
                            input int sl_len, input int rst_y,
                            input int rel_y, input int tog_y);
    repeat (2) begin
      @(posedge clk); #1;
      in_fval = 1'b1;
    end
    for (int y = 0; y < lines; y++) begin
      if (y == rel_y) begin
        reset_n = 1'b1;
        a0 = act;
      end
      if (y == tog_y) crop_en = ~crop_en;
      for (int x = 0; x < ((y == sl_y) ? sl_len : FW); x++) begin
        @(posedge clk); #1;
        in_lval = 1'b1;
        in_d    = pix(x, y);
        if (x == ex0 && y == ey0) pix_cyc = cyc;
        if (y == rst_y && x == 8) begin
          reset_n = 1'b0;
          #1;
          chk("rst_lval", 32'(out_lval), 0);
          chk("rst_fval", 32'(out_fval), 0);
          chk("rst_cnt", 32'(frame_count), 0);
        end
      end
      repeat (HB) begin
        @(posedge clk); #1;
        in_lval = 1'b0;
        in_d    = '0;
      end
    end
    @(posedge clk); #1;
    in_fval  = 1'b0;
    fall_cyc = cyc;
    repeat (VB) @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    crop_en = 1'b1;
    in_d    = '0;
    in_fval = 1'b0;
    in_lval = 1'b0;
    ex0     = X0;
    ey0     = Y0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_d", 32'(out_d), 0);
    chk("rst_out_fval", 32'(out_fval), 0);
    chk("rst_out_lval", 32'(out_lval), 0);
    chk("rst_frame_count", 32'(frame_count), 0);
    chk("rst_line_len", 32'(last_line_len), 0);
    chk("rst_frame_lines", 32'(last_frame_lines), 0);
    chk("rst_short_frame", 32'(short_frame), 0);
    chk("rst_short_line", 32'(short_line), 0);

    send_frame(FH, -1, 0, -1, 4, -1);
    chk("skip_act", act - a0, 0);
    chk("skip_cnt", 32'(frame_count), 0);
    chk("skip_lines", 32'(last_frame_lines), 0);

    snap();
    send_frame(FH, -1, 0, -1, -1, -1);
    chk("crop_bursts", bursts - b0, H);
    chk("crop_len0", blen[b0], W);
    chk("crop_len_last", blen[b0+H-1], W);
    chk("crop_d0", 32'(bd0[b0]), 32'(pix(X0, Y0)));
    chk("crop_lat", bcyc[b0] - pix_cyc, 2);
    chk("crop_data", derr - d0, 0);
    chk("crop_cnt", 32'(frame_count), 1);
    chk("crop_line_len", 32'(last_line_len), FW);
    chk("crop_lines", 32'(last_frame_lines), FH);
    chk("crop_sf", sf_n - s0, 0);
    chk("crop_sl", sl_n - l0, 0);

    crop_en = 1'b0;
    ex0 = 0;
    ey0 = 0;
    snap();
    send_frame(FH, -1, 0, -1, -1, -1);
    chk("pass_bursts", bursts - b0, FH);
    chk("pass_len0", blen[b0], FW);
    chk("pass_len_last", blen[b0+FH-1], FW);
    chk("pass_d0", 32'(bd0[b0]), 32'(pix(0, 0)));
    chk("pass_lat", bcyc[b0] - pix_cyc, 2);
    chk("pass_data", derr - d0, 0);
    chk("pass_cnt", 32'(frame_count), 2);
    chk("pass_line_len", 32'(last_line_len), FW);
    chk("pass_lines", 32'(last_frame_lines), FH);

    crop_en = 1'b1;
    ex0 = X0;
    ey0 = Y0;
    snap();
    send_frame(6, -1, 0, -1, -1, -1);
    chk("trunc_bursts", bursts - b0, 3);
    chk("trunc_sf", sf_n - s0, 1);
    chk("trunc_fall_lat", ofall_cyc - fall_cyc, 2);
    chk("trunc_cnt", 32'(frame_count), 3);
    chk("trunc_lines", 32'(last_frame_lines), 6);
    chk("trunc_data", derr - d0, 0);

    snap();
    send_frame(FH, 5, 9, -1, -1, -1);
    chk("sline_sl", sl_n - l0, 1);
    chk("sline_len", blen[b0+2], 5);
    chk("sline_next", blen[b0+3], W);
    chk("sline_bursts", bursts - b0, H);
    chk("sline_sf", sf_n - s0, 0);
    chk("sline_cnt", 32'(frame_count), 4);
    chk("sline_data", derr - d0, 0);

    snap();
    send_frame(FH, -1, 0, -1, -1, 2);
    chk("tog_cur_bursts", bursts - b0, H);
    chk("tog_cur_cnt", 32'(frame_count), 5);
    ex0 = 0;
    ey0 = 0;
    send_frame(FH, -1, 0, -1, -1, -1);
    chk("tog_next_bursts", bursts - b0, H + FH);
    chk("tog_next_len", blen[b0+H], FW);
    chk("tog_data", derr - d0, 0);
    chk("tog_cnt", 32'(frame_count), 6);

    crop_en = 1'b1;
    ex0 = X0;
    ey0 = Y0;
    send_frame(FH, -1, 0, 5, 7, -1);
    chk("midrst_act", act - a0, 0);
    chk("midrst_cnt", 32'(frame_count), 0);
    snap();
    send_frame(FH, -1, 0, -1, -1, -1);
    chk("after_bursts", bursts - b0, H);
    chk("after_len0", blen[b0], W);
    chk("after_data", derr - d0, 0);
    chk("after_cnt", 32'(frame_count), 1);
    chk("after_lines", 32'(last_frame_lines), FH);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/camera_raw_window_crop.md
# camera_raw_window_crop

Raw-Bayer front-end between the D8M parallel pins and the camera capture conduit (`camera_d`/`camera_fval`/`camera_lval`) of the camera Qsys system, clocked by the sensor pixel clock. It discards the partial frame in progress at reset and crops a programmable pixel/line window from each frame. It also regenerates clean `fval`/`lval` for the capture IP and reports frame count plus line/frame-length diagnostics.

## Interface
Parameters:
- `DATA_W`, 12, raw pixel width
- `CNT_W`, 12, width of pixel and line counters
- `CROP_X0`, 16, first kept pixel index in a line
- `CROP_Y0`, 8, first kept line index in a frame
- `CROP_W`, 800, kept pixels per line
- `CROP_H`, 480, kept lines per frame

Ports:
- `clk`  in  1  sensor pixel clock (pixclk domain)
- `reset_n`  in  1  asynchronous, active-low reset
- `crop_en`  in  1  1 = crop, 0 = full-frame passthrough; sampled at frame start only
- `in_d`  in  DATA_W  sensor pixel data
- `in_fval`  in  1  sensor frame valid
- `in_lval`  in  1  sensor line valid
- `out_d`  out  DATA_W  pixel data to capture conduit
- `out_fval`  out  1  cropped frame valid
- `out_lval`  out  1  cropped line valid
- `frame_count`  out  16  completed output frames, wraps
- `last_line_len`  out  CNT_W  lval-high cycles of the most recent line
- `last_frame_lines`  out  CNT_W  lines in the most recent frame
- `short_frame`  out  1  one-cycle pulse: frame ended before window complete
- `short_line`  out  1  one-cycle pulse: window line ended before `CROP_X0+CROP_W` pixels

## Operation
- Inputs are registered once (`d_r`, `fval_r`, `lval_r`). All logic uses the registered copies.
- FSM states:
  - SKIP: reset state; holds until `fval_r`=0.
  - WAIT: waits for `fval_r` rising; on the rise, latches `crop_en` into `mode` and enters FRAME.
  - FRAME: on `fval_r` falling, returns to WAIT.
- `x`: cleared while `lval_r`=0; +1 per `lval_r`-high cycle; saturates at all-ones. The first pixel of a line has `x`=0.
- `y`: cleared while `fval_r`=0; +1 on each `lval_r` falling edge; saturates.
- Window hit (mode=1): `CROP_Y0<=y<CROP_Y0+CROP_H` and `CROP_X0<=x<CROP_X0+CROP_W`. In mode=0 every FRAME pixel hits.
- `out_lval` = FRAME & `lval_r` & hit. `out_d` = `d_r` when hit, else 0.
- `out_fval`:
  - Rises when FRAME and `y`==`CROP_Y0` (immediately at frame start if `CROP_Y0`=0).
  - Falls when `y` reaches `CROP_Y0+CROP_H` or `fval_r` falls, whichever is first.
  - In mode=0 it mirrors `fval_r` within FRAME.
- `frame_count` increments on each `out_fval` falling edge.
- On each `lval_r` fall, `last_line_len`←`x`. On each `fval_r` fall in FRAME, `last_frame_lines`←`y`.
- `short_frame` pulses when `fval_r` falls in FRAME with mode=1 and `y`<`CROP_Y0+CROP_H`.
- `short_line` pulses when `lval_r` falls on a window line with `x`<`CROP_X0+CROP_W`.
- `lval_r` high while `fval_r` low: ignored; no counting, no output.

## Timing
- Latency `in_*` → `out_*`: 2 cycles (input register plus output register). Fixed in both modes.
- Reset values: all outputs 0, counters 0, state SKIP.
- Reset mid-frame: outputs drop to 0 asynchronously. After release, the remainder of that frame is discarded and the first full frame is output.
- `crop_en` changes mid-frame take effect at the next `fval` rise only.
- A simultaneous `lval` and `fval` fall updates both diagnostics in the same cycle, and `y` clears.
- Parameters must satisfy `CROP_X0+CROP_W` and `CROP_Y0+CROP_H` < 2^CNT_W. Compare at CNT_W+1 bits.

## Structure
- Package `camera_crop_pkg`: FSM state enum (SKIP/WAIT/FRAME), counter width localparam, window-hit compare function.
- One sub-module, `camera_sync_counter`: x/y counters with edge detect, saturation, and length capture. The top keeps the FSM, gating, and status.

## Test plan
- Reset released mid-frame (fval high, line 100) → no `out_*` activity until the next fval rise; first frame output complete.
- 1000×600 frame, crop 16/8/800/480 → exactly 480 `out_lval` bursts of 800 cycles each; first `out_d` = sensor pixel (16,8), seen 2 cycles after input; `frame_count`=1.
- `crop_en`=0 with the same frame → 600 bursts of 1000 cycles; `last_line_len`=1000, `last_frame_lines`=600.
- Frame truncated to 300 lines → `short_frame` pulse, `out_fval` falls 2 cycles after the `in_fval` fall, `frame_count` still increments.
- One window line only 500 pixels long → `short_line` pulse; that burst is 484 cycles; following lines normal.
- `crop_en` toggled mid-frame → current frame unchanged, next frame in new mode.
